// File: rtl/digit_argmax_reader.sv
// Argmax reader: consumes CLASS_COUNT signed activations per frame and reports the winning class index.
// Optional winner value / confidence margin outputs are enabled by defining ARGMAX_CONFIDENCE_EN.
module digit_argmax_reader #(
  parameter int unsigned CLASS_COUNT = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned IDX_W       = (CLASS_COUNT > 1) ? $clog2(CLASS_COUNT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_class,
  output logic              frame_err
`ifdef ARGMAX_CONFIDENCE_EN
  ,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_margin
`endif
);

  localparam int unsigned LAST_K = CLASS_COUNT - 1;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_DONE    = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]  class_q, class_d;
  logic              frame_err_q, frame_err_d;

  logic beat_acc_c;
  logic first_beat_c;
  logic last_beat_c;
  logic new_max_c;

  assign beat_acc_c   = in_valid & in_ready;
  assign first_beat_c = (cnt_q == '0);
  assign last_beat_c  = (cnt_q == IDX_W'(LAST_K));
  assign new_max_c    = $signed(in_data) > $signed(max_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: if (beat_acc_c && last_beat_c) state_d = S_DONE;
      S_DONE:    if (out_ready) state_d = S_COLLECT;
      default:   state_d = S_COLLECT;
    endcase
  end

  // Handshake outputs; in_ready is gated by rst so nothing is taken during reset
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_COLLECT: in_ready  = ~rst;
      S_DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Running argmax; strict compare keeps the lowest index on ties
  always_comb begin
    cnt_d       = cnt_q;
    max_d       = max_q;
    class_d     = class_q;
    frame_err_d = 1'b0;
    if (beat_acc_c) begin
      cnt_d       = last_beat_c ? '0 : cnt_q + IDX_W'(1);
      frame_err_d = in_last ^ last_beat_c;
      if (first_beat_c) begin
        max_d   = in_data;
        class_d = '0;
      end else if (new_max_c) begin
        max_d   = in_data;
        class_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      max_q       <= '0;
      class_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      class_q     <= class_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_class = class_q;
  assign frame_err = frame_err_q;

`ifdef ARGMAX_CONFIDENCE_EN
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] sec_q, sec_d;
  logic [DATA_W-1:0] margin_q, margin_d;
  logic [DATA_W:0]   diff_c;

  // Runner-up tracker; a demoted max becomes the new runner-up
  always_comb begin
    sec_d = sec_q;
    if (beat_acc_c) begin
      if (first_beat_c) begin
        sec_d = MOST_NEG;
      end else if (new_max_c) begin
        sec_d = max_q;
      end else if ($signed(in_data) > $signed(sec_q)) begin
        sec_d = in_data;
      end
    end
  end

  // Margin latched on DONE entry from the frame's final max/runner-up
  always_comb begin
    diff_c   = {max_d[DATA_W-1], max_d} - {sec_d[DATA_W-1], sec_d};
    margin_d = margin_q;
    if (beat_acc_c && last_beat_c) begin
      if (CLASS_COUNT == 1) begin
        margin_d = '0;
      end else if (diff_c[DATA_W]) begin
        margin_d = '1;
      end else begin
        margin_d = diff_c[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q    <= '0;
      margin_q <= '0;
    end else begin
      sec_q    <= sec_d;
      margin_q <= margin_d;
    end
  end

  assign out_max    = max_q;
  assign out_margin = margin_q;
`endif

endmodule

// File: tb/tb_digit_argmax_reader.sv
// Directed testbench for digit_argmax_reader (CLASS_COUNT=10, DATA_W=32).
// Confidence checks run only when ARGMAX_CONFIDENCE_EN is defined.
module tb_digit_argmax_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_class;
  logic        frame_err;
`ifdef ARGMAX_CONFIDENCE_EN
  logic [31:0] out_max;
  logic [31:0] out_margin;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic signed [31:0] frm [10];
  logic [9:0]         fe_obs;
  logic [9:0]         ov_obs;

  digit_argmax_reader #(
    .CLASS_COUNT(10),
    .DATA_W     (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .frame_err(frame_err)
`ifdef ARGMAX_CONFIDENCE_EN
    ,
    .out_max   (out_max),
    .out_margin(out_margin)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Drives beats start..start+nb-1 of frm; starts and ends on a negedge.
  task automatic drive_frame(input int start, input int nb, input logic [9:0] lastm);
    int waitc;
    fe_obs = '0;
    ov_obs = '0;
    for (int k = start; k < start + nb; k++) begin
      in_valid = 1'b1;
      in_data  = frm[k];
      in_last  = lastm[k];
      waitc    = 0;
      while (!in_ready && waitc < 20) begin
        @(negedge clk);
        waitc++;
      end
      n_checks++;
      if (!in_ready) begin
        n_fails++;
        $display("FAIL beat_ready: beat %0d in_ready=%b required 1", k, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      fe_obs[k] = frame_err;
      ov_obs[k] = out_valid;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 32'd5; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fails++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_checks++;
    if (out_class !== 4'd0) begin n_fails++; $display("FAIL reset_out_class: got %0d required 0", out_class); end
    n_checks++;
    if (frame_err !== 1'b0) begin n_fails++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fails++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_basic();
    frm = '{0, 5, 3, 9, 2, 9, 1, 0, 0, 4};
    out_ready = 1'b1;
    drive_frame(0, 10, 10'h200);
    n_checks++;
    if (ov_obs !== 10'h200) begin n_fails++; $display("FAIL basic_latency: out_valid per beat %b required %b", ov_obs, 10'h200); end
    n_checks++;
    if (fe_obs !== 10'h000) begin n_fails++; $display("FAIL basic_frame_err: %b required %b", fe_obs, 10'h000); end
    n_checks++;
    if (out_class !== 4'd3) begin n_fails++; $display("FAIL basic_tie_class: got %0d required 3", out_class); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fails++; $display("FAIL basic_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_signed();
    frm = '{-7, -2, -9, -3, -5, -4, -10, -6, -20, -8};
    out_ready = 1'b1;
    drive_frame(0, 10, 10'h200);
    n_checks++;
    if (out_valid !== 1'b1 || out_class !== 4'd1) begin
      n_fails++; $display("FAIL signed_class: out_valid=%b class=%0d required 1/1", out_valid, out_class);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    frm = '{5, 1, 2, 3, 4, 6, 77, 7, 8, 9};
    out_ready = 1'b0;
    drive_frame(0, 10, 10'h200);
    in_valid = 1'b1; in_data = 32'd1000; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_class !== 4'd6 || in_ready !== 1'b0 || frame_err !== 1'b0) begin
        n_fails++;
        $display("FAIL hold_cycle%0d: out_valid=%b class=%0d in_ready=%b frame_err=%b required 1/6/0/0",
                 c, out_valid, out_class, in_ready, frame_err);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fails++; $display("FAIL hold_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_frame_err();
    frm = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    out_ready = 1'b1;
    drive_frame(0, 10, 10'h210);
    n_checks++;
    if (fe_obs !== 10'h010) begin n_fails++; $display("FAIL early_last_err: %b required %b", fe_obs, 10'h010); end
    n_checks++;
    if (ov_obs !== 10'h200 || out_class !== 4'd5) begin
      n_fails++; $display("FAIL early_last_frame: out_valid %b class %0d required %b/5", ov_obs, out_class, 10'h200);
    end
    @(negedge clk);
    frm = '{2, 7, 1, 8, 2, 8, 1, 8, 2, 8};
    drive_frame(0, 10, 10'h000);
    n_checks++;
    if (fe_obs !== 10'h200) begin n_fails++; $display("FAIL missing_last_err: %b required %b", fe_obs, 10'h200); end
    n_checks++;
    if (out_class !== 4'd3) begin n_fails++; $display("FAIL missing_last_class: got %0d required 3", out_class); end
    @(negedge clk);
    n_checks++;
    if (frame_err !== 1'b0) begin n_fails++; $display("FAIL err_pulse_width: got %b required 0", frame_err); end
  endtask

  task automatic test_stall();
    frm = '{4, 8, 15, 16, 23, 42, -1, 0, 7, 41};
    out_ready = 1'b1;
    drive_frame(0, 5, 10'h200);
    repeat (4) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fails++; $display("FAIL stall_idle: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    drive_frame(5, 5, 10'h200);
    n_checks++;
    if (ov_obs !== 10'h200 || out_class !== 4'd5) begin
      n_fails++; $display("FAIL stall_resume: out_valid %b class %0d required %b/5", ov_obs, out_class, 10'h200);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    frm = '{50, 60, 70, 80, 90, 99, 0, 0, 0, 0};
    out_ready = 1'b1;
    drive_frame(0, 6, 10'h200);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fails++; $display("FAIL midrst_in_ready: got %b required 0", in_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_fails++; $display("FAIL midrst_no_output: out_valid=%b frame_err=%b required 0/0", out_valid, frame_err);
    end
    frm = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive_frame(0, 10, 10'h200);
    n_checks++;
    if (ov_obs !== 10'h200) begin n_fails++; $display("FAIL midrst_count: out_valid per beat %b required %b", ov_obs, 10'h200); end
    n_checks++;
    if (out_class !== 4'd0) begin n_fails++; $display("FAIL midrst_class: got %0d required 0", out_class); end
    @(negedge clk);
  endtask

`ifdef ARGMAX_CONFIDENCE_EN
  task automatic test_confidence();
    frm = '{10, 40, 25, 0, 0, 0, 0, 0, 0, 0};
    out_ready = 1'b1;
    drive_frame(0, 10, 10'h200);
    n_checks++;
    if (out_class !== 4'd1 || out_max !== 32'd40 || out_margin !== 32'd15) begin
      n_fails++; $display("FAIL conf_margin: class=%0d max=%0d margin=%0d required 1/40/15", out_class, out_max, out_margin);
    end
    @(negedge clk);
    frm = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
    drive_frame(0, 10, 10'h200);
    n_checks++;
    if (out_class !== 4'd0 || out_max !== 32'd7 || out_margin !== 32'd0) begin
      n_fails++; $display("FAIL conf_tie: class=%0d max=%0d margin=%0d required 0/7/0", out_class, out_max, out_margin);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_frame_err();
    test_stall();
    test_reset_midframe();
`ifdef ARGMAX_CONFIDENCE_EN
    test_confidence();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
